// File: rtl/pe_sink.sv
// Hoplite torus ejection endpoint: absorbs exit-port packets addressed to this PE,
// queues the payload in a small FIFO and drains it over valid/ready.
module pe_sink #(
  parameter int P_W     = 16,
  parameter int X_AW    = 2,
  parameter int Y_AW    = 2,
  parameter int X_POS   = 0,
  parameter int Y_POS   = 0,
  parameter int FIFO_AW = 3,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [P_W-1:0]              in_pkt,
  input  logic                        in_vld,
  output logic [P_W-X_AW-Y_AW-1:0]    out_data,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [FIFO_AW:0]            level,
  output logic [CNT_W-1:0]            rx_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic [CNT_W-1:0]            mis_cnt,
  output logic                        ovf
);

  localparam int D_W   = P_W - X_AW - Y_AW;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [X_AW-1:0]    X_ID    = X_AW'(X_POS);
  localparam logic [Y_AW-1:0]    Y_ID    = Y_AW'(Y_POS);
  localparam logic [FIFO_AW:0]   LVL_MAX = (FIFO_AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  logic [D_W-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg, level_next;
  logic [CNT_W-1:0]   rx_cnt_reg, drop_cnt_reg, mis_cnt_reg;
  logic               ovf_reg;

  logic [X_AW-1:0] dst_x;
  logic [Y_AW-1:0] dst_y;
  logic            match, full, pop, push, drop, miss;

  assign dst_x = in_pkt[P_W-1 -: X_AW];
  assign dst_y = in_pkt[P_W-X_AW-1 -: Y_AW];
  assign match = (dst_x == X_ID) && (dst_y == Y_ID);
  assign full  = (level_reg == LVL_MAX);
  assign pop   = out_vld & out_rdy;
  // The exit port cannot stall, so a full FIFO still takes the packet if the head leaves now.
  assign push  = in_vld & match & (~full | pop);
  assign drop  = in_vld & match & full & ~pop;
  assign miss  = in_vld & ~match;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + (FIFO_AW+1)'(1);
      2'b01:   level_next = level_reg - (FIFO_AW+1)'(1);
      default: level_next = level_reg;
    endcase
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && v != CNT_MAX) return v + CNT_W'(1);
    return v;
  endfunction

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_pkt[D_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      rx_cnt_reg   <= '0;
      drop_cnt_reg <= '0;
      mis_cnt_reg  <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      level_reg    <= level_next;
      rx_cnt_reg   <= sat_inc(rx_cnt_reg, push);
      drop_cnt_reg <= sat_inc(drop_cnt_reg, drop);
      mis_cnt_reg  <= sat_inc(mis_cnt_reg, miss);
      if (drop) ovf_reg <= 1'b1;
    end
  end

  assign out_data = mem[rd_ptr_reg];
  assign out_vld  = (level_reg != '0);
  assign level    = level_reg;
  assign rx_cnt   = rx_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
  assign mis_cnt  = mis_cnt_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_pe_sink.sv
// Directed bench for pe_sink: ordering, misroute, overflow, full push+pop,
// async reset and counter saturation (second instance with 4-bit counters).
module tb_pe_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_pkt = '0;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b0;
  logic [11:0] out_data;
  logic        out_vld;
  logic [3:0]  level;
  logic [15:0] rx_cnt, drop_cnt, mis_cnt;
  logic        ovf;

  logic [15:0] s_pkt = '0;
  logic        s_vld = 1'b0;
  logic [11:0] s_data;
  logic        s_out_vld;
  logic [3:0]  s_level;
  logic [3:0]  s_rx, s_drop, s_mis;
  logic        s_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_sink dut (
    .clk(clk), .rst(rst), .in_pkt(in_pkt), .in_vld(in_vld),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .level(level), .rx_cnt(rx_cnt), .drop_cnt(drop_cnt),
    .mis_cnt(mis_cnt), .ovf(ovf)
  );

  pe_sink #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_pkt(s_pkt), .in_vld(s_vld),
    .out_data(s_data), .out_vld(s_out_vld), .out_rdy(1'b1),
    .level(s_level), .rx_cnt(s_rx), .drop_cnt(s_drop),
    .mis_cnt(s_mis), .ovf(s_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pkt(input logic [1:0] x, input logic [1:0] y, input logic [11:0] d);
    return {x, y, d};
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    check("rst_vld", out_vld, 0);
    check("rst_level", level, 0);
    check("rst_cnts", {rx_cnt, drop_cnt}, 0);
    check("rst_mis_ovf", {mis_cnt, 15'd0, ovf}, 0);
    rst = 1'b1;
    tick();

    // Three packets streamed through with the consumer ready
    out_rdy = 1'b1;
    in_vld = 1'b1; in_pkt = pkt(2'd0, 2'd0, 12'h123);
    tick();
    check("t1_vld1", out_vld, 1);
    check("t1_data1", out_data, 12'h123);
    in_pkt = pkt(2'd0, 2'd0, 12'h456);
    tick();
    check("t1_data2", out_data, 12'h456);
    in_pkt = pkt(2'd0, 2'd0, 12'h789);
    tick();
    check("t1_data3", out_data, 12'h789);
    in_vld = 1'b0;
    tick();
    check("t1_level", level, 0);
    check("t1_rx", rx_cnt, 3);

    // Misrouted packet
    in_vld = 1'b1; in_pkt = pkt(2'd1, 2'd2, 12'habc);
    tick();
    in_vld = 1'b0;
    check("t2_vld", out_vld, 0);
    check("t2_mis", mis_cnt, 1);
    check("t2_rx", rx_cnt, 3);

    // Overflow: 10 packets into 8 slots with consumer stalled
    out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_vld = 1'b1; in_pkt = pkt(2'd0, 2'd0, 12'h100 + 12'(i));
      tick();
    end
    in_vld = 1'b0;
    tick();
    check("t3_level", level, 8);
    check("t3_rx", rx_cnt, 11);
    check("t3_drop", drop_cnt, 2);
    check("t3_ovf", ovf, 1);
    check("t3_head_hold", out_data, 12'h100);

    // Full FIFO with simultaneous push and pop
    out_rdy = 1'b1; in_vld = 1'b1; in_pkt = pkt(2'd0, 2'd0, 12'h200);
    tick();
    in_vld = 1'b0; out_rdy = 1'b0;
    check("t4_level", level, 8);
    check("t4_drop", drop_cnt, 2);
    check("t4_rx", rx_cnt, 12);

    // Drain: 0x101..0x107 then 0x200
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_drain%0d", i), out_data, (i < 7) ? 32'h101 + 32'(i) : 32'h200);
      tick();
    end
    check("t4_empty", {out_vld, level}, 0);

    // Async reset mid-operation with level=5
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_vld = 1'b1; in_pkt = pkt(2'd0, 2'd0, 12'h300 + 12'(i));
      tick();
    end
    in_vld = 1'b0;
    check("t5_level5", level, 5);
    #2 rst = 1'b0;
    #1;
    check("t5_async_vld_lvl", {out_vld, level}, 0);
    check("t5_async_cnts", {rx_cnt, drop_cnt}, 0);
    check("t5_async_mis_ovf", {mis_cnt, 15'd0, ovf}, 0);
    tick();
    rst = 1'b1;
    in_vld = 1'b1; in_pkt = pkt(2'd0, 2'd0, 12'h055);
    tick();
    in_vld = 1'b0;
    check("t5_resume_data", out_data, 12'h055);
    check("t5_resume_lvl", level, 1);
    check("t5_resume_rx", rx_cnt, 1);

    // Saturation on the 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      s_vld = 1'b1; s_pkt = pkt(2'd0, 2'd0, 12'(i));
      tick();
      if (i == 13) check("t6_rx14", s_rx, 14);
    end
    s_vld = 1'b0;
    tick();
    check("t6_rx_sat", s_rx, 15);
    check("t6_drop", s_drop, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
